// File: rtl/trig_mult_pkg.sv
// Shared widths and the quarter-wave sine kernel used by the trig-product arbiter.
// Angles are unsigned fractions of a full turn; kernel outputs are signed Q1.15.
package trig_mult_pkg;

    function automatic int id_width(input int n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

    function automatic int prod_width(input int a_w, input int b_w);
        return a_w + b_w;
    endfunction

    // Credits run 0..depth inclusive, hence depth+1 states.
    function automatic int credit_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Sine of a 6-bit phase (64 steps per turn), rounded round(32767*sin), Q1.15.
    function automatic logic signed [15:0] sin_q15(input logic [5:0] phase);
        logic [4:0]  idx;
        logic [15:0] mag;
        idx = phase[4] ? (5'd16 - {1'b0, phase[3:0]}) : {1'b0, phase[3:0]};
        case (idx)
            5'd0:    mag = 16'd0;
            5'd1:    mag = 16'd3212;
            5'd2:    mag = 16'd6393;
            5'd3:    mag = 16'd9512;
            5'd4:    mag = 16'd12539;
            5'd5:    mag = 16'd15446;
            5'd6:    mag = 16'd18204;
            5'd7:    mag = 16'd20787;
            5'd8:    mag = 16'd23170;
            5'd9:    mag = 16'd25329;
            5'd10:   mag = 16'd27245;
            5'd11:   mag = 16'd28898;
            5'd12:   mag = 16'd30273;
            5'd13:   mag = 16'd31356;
            5'd14:   mag = 16'd32137;
            5'd15:   mag = 16'd32609;
            default: mag = 16'd32767;
        endcase
        return phase[5] ? -$signed(mag) : $signed(mag);
    endfunction

endpackage

// File: rtl/trig_product_pipe.sv
// Fixed-latency cos(A)*sin(B) datapath with a matching valid/ID delay line.
// There is no stall: results emerge exactly PIPE_LAT cycles after entry.
module trig_product_pipe
    import trig_mult_pkg::*;
#(
    parameter int A_WIDTH  = 16,
    parameter int B_WIDTH  = 16,
    parameter int PIPE_LAT = 3,
    parameter int ID_W     = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [A_WIDTH-1:0]         in_a,
    input  logic [B_WIDTH-1:0]         in_b,
    input  logic [ID_W-1:0]            in_id,
    output logic                       res_valid,
    output logic [ID_W-1:0]            res_id,
    output logic [A_WIDTH+B_WIDTH-1:0] res_product
);
    localparam int PROD_W = prod_width(A_WIDTH, B_WIDTH);

    logic signed [15:0]        cos_q;
    logic signed [15:0]        sin_q;
    logic signed [31:0]        cos_ext;
    logic signed [31:0]        sin_ext;
    logic signed [A_WIDTH-1:0] cos_k;
    logic signed [B_WIDTH-1:0] sin_k;
    logic signed [PROD_W-1:0]  prod_k;
    logic                      unused_bits;

    logic signed [PROD_W-1:0]  prod_p [PIPE_LAT];
    logic [ID_W-1:0]           id_p   [PIPE_LAT];
    logic [PIPE_LAT-1:0]       vld_p;

    // cos(x) is sin(x + quarter turn); only the top 6 angle bits select the phase.
    assign cos_q   = sin_q15(in_a[A_WIDTH-1 -: 6] + 6'd16);
    assign sin_q   = sin_q15(in_b[B_WIDTH-1 -: 6]);
    assign cos_ext = {cos_q, 16'd0};
    assign sin_ext = {sin_q, 16'd0};
    assign cos_k   = cos_ext[31 -: A_WIDTH];
    assign sin_k   = sin_ext[31 -: B_WIDTH];
    assign prod_k  = PROD_W'(cos_k) * PROD_W'(sin_k);

    assign unused_bits = ^{in_a, in_b, cos_ext, sin_ext};

    // Stage 0 registers the product; later stages form a pure delay line.
    always_ff @(posedge clk) begin
        prod_p[0] <= prod_k;
        id_p[0]   <= in_id;
        for (int i = 1; i < PIPE_LAT; i++) begin
            prod_p[i] <= prod_p[i-1];
            id_p[i]   <= id_p[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= in_valid;
            for (int i = 1; i < PIPE_LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    assign res_valid   = vld_p[PIPE_LAT-1];
    assign res_id      = id_p[PIPE_LAT-1];
    assign res_product = prod_p[PIPE_LAT-1];

endmodule

// File: rtl/trig_mult_arbiter.sv
// Round-robin front end sharing one trig-product pipe between N_REQ requesters,
// with credit flow control into an in-order tagged result FIFO.
module trig_mult_arbiter
    import trig_mult_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int A_WIDTH    = 16,
    parameter int B_WIDTH    = 16,
    parameter int PIPE_LAT   = 3,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                                   CLK,
    input  logic                                   RST,
    input  logic [N_REQ-1:0]                       REQ_VALID,
    output logic [N_REQ-1:0]                       REQ_READY,
    input  logic [N_REQ*A_WIDTH-1:0]               REQ_A,
    input  logic [N_REQ*B_WIDTH-1:0]               REQ_B,
    output logic                                   OUT_VALID,
    input  logic                                   OUT_READY,
    output logic [id_width(N_REQ)-1:0]             OUT_ID,
    output logic [prod_width(A_WIDTH, B_WIDTH)-1:0] OUT_PRODUCT,
    output logic                                   BUSY
);
    localparam int ID_W   = id_width(N_REQ);
    localparam int SUM_W  = ID_W + 1;
    localparam int PROD_W = prod_width(A_WIDTH, B_WIDTH);
    localparam int CRED_W = credit_width(FIFO_DEPTH);
    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam logic [CRED_W-1:0] FULL_CREDITS = CRED_W'(FIFO_DEPTH);

    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    grant;
    logic [SUM_W-1:0]   cand;
    logic               grant_found;
    logic               issue;
    logic               pop;
    logic [CRED_W-1:0]  credits;
    logic [A_WIDTH-1:0] issue_a;
    logic [B_WIDTH-1:0] issue_b;

    logic               res_valid;
    logic [ID_W-1:0]    res_id;
    logic [PROD_W-1:0]  res_product;

    logic [ADDR_W:0]    wr_ptr;
    logic [ADDR_W:0]    rd_ptr;
    logic [ID_W-1:0]    id_mem   [FIFO_DEPTH];
    logic [PROD_W-1:0]  prod_mem [FIFO_DEPTH];
    logic               fifo_empty;
    logic               fifo_full;

    // Scan from ptr upward with wrap; the lowest offset that is valid wins.
    always_comb begin
        grant       = ptr;
        grant_found = 1'b0;
        cand        = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + SUM_W'(k);
            if (cand >= SUM_W'(N_REQ)) begin
                cand = cand - SUM_W'(N_REQ);
            end
            if (REQ_VALID[cand[ID_W-1:0]]) begin
                grant       = cand[ID_W-1:0];
                grant_found = 1'b1;
            end
        end
    end

    always_comb begin
        REQ_READY = '0;
        if (!RST && grant_found && credits != '0) begin
            REQ_READY[grant] = 1'b1;
        end
    end

    assign issue   = |(REQ_VALID & REQ_READY);
    assign pop     = OUT_VALID && OUT_READY;
    assign issue_a = REQ_A[grant*A_WIDTH +: A_WIDTH];
    assign issue_b = REQ_B[grant*B_WIDTH +: B_WIDTH];

    trig_product_pipe #(
        .A_WIDTH  (A_WIDTH),
        .B_WIDTH  (B_WIDTH),
        .PIPE_LAT (PIPE_LAT),
        .ID_W     (ID_W)
    ) u_pipe (
        .clk         (CLK),
        .rst         (RST),
        .in_valid    (issue),
        .in_a        (issue_a),
        .in_b        (issue_b),
        .in_id       (grant),
        .res_valid   (res_valid),
        .res_id      (res_id),
        .res_product (res_product)
    );

    // Credits cover in-flight plus buffered results, so the pipe can never overrun the FIFO.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr     <= '0;
            credits <= FULL_CREDITS;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
        end else begin
            if (issue) begin
                ptr <= (grant == ID_W'(N_REQ - 1)) ? '0 : grant + 1'b1;
            end
            case ({issue, pop})
                2'b10:   credits <= credits - 1'b1;
                2'b01:   credits <= credits + 1'b1;
                default: credits <= credits;
            endcase
            if (res_valid) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (res_valid) begin
            id_mem[wr_ptr[ADDR_W-1:0]]   <= res_id;
            prod_mem[wr_ptr[ADDR_W-1:0]] <= res_product;
        end
    end

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                        (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

    assign OUT_VALID   = !fifo_empty;
    assign OUT_ID      = fifo_empty ? '0 : id_mem[rd_ptr[ADDR_W-1:0]];
    assign OUT_PRODUCT = fifo_empty ? '0 : prod_mem[rd_ptr[ADDR_W-1:0]];
    assign BUSY        = (credits != FULL_CREDITS);

    assert property (@(posedge CLK) disable iff (RST) !(fifo_full && res_valid));

endmodule

// File: tb/tb_trig_mult_arbiter.sv
// Directed bench for trig_mult_arbiter: single-op vector table plus arbitration,
// backpressure, credit and mid-flight reset sequences against an in-order scoreboard.
module tb_trig_mult_arbiter;
    localparam int N     = 4;
    localparam int AW    = 16;
    localparam int BW    = 16;
    localparam int LAT   = 3;
    localparam int DEPTH = 8;
    localparam real PI   = 3.14159265358979;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_a;
    logic [N*BW-1:0] req_b;
    logic            out_valid;
    logic            out_ready;
    logic [1:0]      out_id;
    logic [31:0]     out_product;
    logic            busy;

    int checks   = 0;
    int failures = 0;
    int popped   = 0;
    int exp_ptr  = 0;
    int lat;

    typedef struct {
        logic [1:0]  id;
        logic [15:0] a;
        logic [15:0] b;
    } op_t;

    typedef struct {
        logic [1:0]  id;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] prod;
    } vec_t;

    op_t  sbq[$];
    vec_t vecs[8];

    always #5 clk = ~clk;

    trig_mult_arbiter #(
        .N_REQ      (N),
        .A_WIDTH    (AW),
        .B_WIDTH    (BW),
        .PIPE_LAT   (LAT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .CLK         (clk),
        .RST         (rst),
        .REQ_VALID   (req_valid),
        .REQ_READY   (req_ready),
        .REQ_A       (req_a),
        .REQ_B       (req_b),
        .OUT_VALID   (out_valid),
        .OUT_READY   (out_ready),
        .OUT_ID      (out_id),
        .OUT_PRODUCT (out_product),
        .BUSY        (busy)
    );

    function automatic int q15(input real x);
        return int'($floor(32767.0 * x + 0.5));
    endfunction

    function automatic logic [31:0] model_prod(input logic [15:0] a, input logic [15:0] b);
        int ia;
        int ib;
        int c;
        int s;
        ia = int'(a[15:10]);
        ib = int'(b[15:10]);
        c  = q15($cos(2.0 * PI * ia / 64.0));
        s  = q15($sin(2.0 * PI * ib / 64.0));
        return 32'(c * s);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    // One clock: outputs are compared at the falling edge, inputs change 1 after the rising edge.
    task automatic tick();
        op_t e;
        @(negedge clk);
        if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                check("unexpected_out", 32'(out_valid), 32'd0);
            end else begin
                e = sbq.pop_front();
                check("sb_id", 32'(out_id), 32'(e.id));
                check("sb_product", out_product, model_prod(e.a, e.b));
                popped++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue_all_cycle(input int n);
        for (int i = 0; i < N; i++) begin
            req_a[i*AW +: AW] = 16'((n * 5 + i * 3) << 10);
            req_b[i*BW +: BW] = 16'((n * 7 + i * 11 + 1) << 10);
        end
        req_valid = '1;
        #1;
        check("grant", 32'(req_ready), 32'(1 << exp_ptr));
        sbq.push_back('{id: 2'(exp_ptr), a: req_a[exp_ptr*AW +: AW], b: req_b[exp_ptr*BW +: BW]});
        exp_ptr = (exp_ptr + 1) % N;
        tick();
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        req_valid = '0;
        out_ready = 1'b1;
        while ((sbq.size() != 0 || out_valid) && n < limit) begin
            tick();
            n++;
        end
        check("drain_left", 32'(sbq.size()), 32'd0);
        check("drain_idle", {30'd0, out_valid, busy}, 32'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        vecs[0] = '{2'd2, 16'h0000, 16'h0000, 32'h0000_0000};
        vecs[1] = '{2'd1, 16'h0000, 16'h4000, 32'h3FFF_0001};
        vecs[2] = '{2'd3, 16'h8000, 16'h4000, 32'hC000_FFFF};
        vecs[3] = '{2'd0, 16'h4000, 16'h4000, 32'h0000_0000};
        vecs[4] = '{2'd0, 16'h0000, 16'hC000, 32'hC000_FFFF};
        vecs[5] = '{2'd1, 16'h2000, 16'h2000, 32'd536848900};
        vecs[6] = '{2'd3, 16'h0400, 16'h0400, 32'd104740108};
        vecs[7] = '{2'd2, 16'h03FF, 16'h43FF, 32'h3FFF_0001};

        rst       = 1'b1;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        out_ready = 1'b0;

        // Reset held two cycles with every requester asking.
        for (int c = 0; c < 2; c++) begin
            tick();
            check("rst_ready", 32'(req_ready), 32'd0);
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_out_id", 32'(out_id), 32'd0);
            check("rst_out_product", out_product, 32'd0);
        end
        rst = 1'b0;
        #1;
        check("first_grant", 32'(req_ready), 32'd1);
        req_valid = '0;
        tick();

        // Single-op vectors: latency, tag and hand-computed product.
        for (int v = 0; v < 8; v++) begin
            req_valid = '0;
            req_valid[vecs[v].id] = 1'b1;
            req_a[vecs[v].id*AW +: AW] = vecs[v].a;
            req_b[vecs[v].id*BW +: BW] = vecs[v].b;
            #1;
            check("tbl_ready", 32'(req_ready), 32'(1 << vecs[v].id));
            sbq.push_back('{id: vecs[v].id, a: vecs[v].a, b: vecs[v].b});
            tick();
            req_valid = '0;
            lat = 1;
            while (!out_valid && lat < 20) begin
                tick();
                lat++;
            end
            check("tbl_latency", lat, LAT + 1);
            check("tbl_id", 32'(out_id), 32'(vecs[v].id));
            check("tbl_product", out_product, vecs[v].prod);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            check("tbl_empty", {30'd0, out_valid, busy}, 32'd0);
        end

        // Fairness: all requesters valid, consumer always ready, 12 ops.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_ptr = 0;
        out_ready = 1'b1;
        popped = 0;
        for (int n = 0; n < 12; n++) issue_all_cycle(n);
        drain(40);
        check("fair_count", popped, 12);

        // Backpressure: exactly DEPTH accepts, then the head must hold still.
        out_ready = 1'b0;
        popped = 0;
        for (int n = 0; n < DEPTH; n++) issue_all_cycle(20 + n);
        for (int c = 0; c < 5; c++) begin
            check("bp_ready", 32'(req_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_head_id", 32'(out_id), 32'(sbq[0].id));
            check("bp_head_product", out_product, model_prod(sbq[0].a, sbq[0].b));
            tick();
        end
        drain(40);
        check("bp_count", popped, DEPTH);

        // Credits at 1: pop and issue together keep one accept per cycle.
        out_ready = 1'b0;
        for (int n = 0; n < DEPTH - 1; n++) issue_all_cycle(40 + n);
        out_ready = 1'b1;
        for (int n = 0; n < 6; n++) issue_all_cycle(50 + n);
        out_ready = 1'b0;
        issue_all_cycle(60);
        #1;
        check("credit_stop", 32'(req_ready), 32'd0);
        check("credit_busy", 32'(busy), 32'd1);
        drain(40);

        // Reset with three ops in flight and two buffered.
        out_ready = 1'b0;
        for (int n = 0; n < 5; n++) issue_all_cycle(70 + n);
        check("mid_buffered", {30'd0, out_valid, busy}, 32'd3);
        req_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sbq.delete();
        exp_ptr = 0;
        out_ready = 1'b1;
        check("mid_rst_idle", {30'd0, out_valid, busy}, 32'd0);
        for (int c = 0; c < 8; c++) begin
            tick();
            check("mid_rst_quiet", 32'(out_valid), 32'd0);
        end
        out_ready = 1'b0;
        for (int n = 0; n < DEPTH; n++) issue_all_cycle(80 + n);
        #1;
        check("mid_rst_credits", 32'(req_ready), 32'd0);
        drain(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
